cic_decim_comb_chain: RTL and testbench
=======================================

Name: cic_decim_comb_chain

Overview:
- Back half of a CIC decimator.
- Takes the integrator-chain output, decimates it by a fixed or run-time-programmable ratio, then passes it through CIC_N cascaded comb stages (y[n] = x[n] − x[n−CIC_M]).
- Emits the MSB-aligned result on an AXI-Stream-like valid-only interface (no tready).

Parameters:
- DW, 32, signed sample width through downsampler and comb chain.
- OUT_DW, 32, output width; must be ≤ DW.
- RATE_DW, 16, width of rate input.
- CIC_R, 10, fixed decimation ratio; reset/maximum ratio when VARIABLE_RATE=1.
- CIC_N, 3, number of comb stages (≥1).
- CIC_M, 1, differential delay per comb (≥1).
- VARIABLE_RATE, 1, 1 = rate programmable via s_axis_rate_*; 0 = fixed CIC_R, rate ports ignored.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- reset_n, input, 1, synchronous active-low reset.
- s_axis_in_tdata, input, DW, signed input sample.
- s_axis_in_tvalid, input, 1, input sample strobe.
- s_axis_rate_tdata, input, RATE_DW, unsigned new decimation ratio.
- s_axis_rate_tvalid, input, 1, rate load strobe.
- m_axis_out_tdata, output, OUT_DW, signed output, bits [DW−1 -: OUT_DW] of the last comb output.
- m_axis_out_tvalid, output, 1, one-cycle pulse per output sample.

Behaviour:
- Reset: reset_n sampled low on a clk edge clears the following; reset mid-stream discards all in-flight samples.
  - Decimation counter → 0.
  - Active rate → CIC_R.
  - All comb delay lines → 0.
  - All pipeline data → 0 and all valid flags → 0.
  - m_axis_out_tdata → 0, m_axis_out_tvalid → 0.
- Downsampler (1-cycle registered):
  - Counts valid inputs.
  - On a valid input with count == rate−1: register that sample, pulse downsampler valid next cycle, count ← 0.
  - On any other valid input: count+1.
  - Cycles without tvalid: no count change.
- Rate load (VARIABLE_RATE=1, s_axis_rate_tvalid=1):
  - Value 0 is ignored.
  - Values > CIC_R are clamped to CIC_R.
  - Otherwise active rate ← value and the counter restarts.
  - Coincident s_axis_in_tvalid is counted as the first sample of the new period: count ← 1, or the sample is emitted immediately if the new rate is 1.
- Rate 1: every valid input is passed through.
- Comb stage (1-cycle registered):
  - On input strobe: out ← in − d[CIC_M−1] (DW-bit two's-complement wrap, no saturation), shift delay line d ← {d, in}, out strobe next cycle.
  - Delay line advances only on strobes, never on idle cycles.
- Stages are chained: stage k strobe/data feed stage k+1.
- Output: m_axis_out_tdata = top OUT_DW bits of the final comb output (truncation, no rounding); m_axis_out_tvalid = final comb strobe.
- Data holds its value between pulses.
- Latency: m_axis_out_tvalid rises exactly CIC_N+1 cycles after the clk edge that accepted the decimating (R-th) input sample.
- Throughput: one input per cycle sustained; at most one output per rate valid inputs.

Test Plan:
- Fixed mode, CIC_R=4, CIC_N=1, CIC_M=1, DW=OUT_DW=16, constant input 5 every cycle -> pulse after every 4th input, 2 cycles later; outputs 5, 0, 0, …
- Fixed mode, CIC_R=2, CIC_N=2, CIC_M=1, ramp input 0,1,2,…,11 -> decimated values 1,3,5,7,9,11; outputs 1, 1, 0, 0, 0, 0, each 3 cycles after the accepting edge.
- Variable mode, CIC_R=8: run at reset rate 8, then load rate 2 mid-stream -> counter restarts, outputs every 2nd valid. Load rate 0 -> unchanged. Load 20 -> behaves as rate 8.
- Gapped tvalid (valid every 3rd cycle), rate 3, CIC_N=1 -> one output per 3 valid inputs; comb delay is unaffected by idle cycles.
- Wrap: DW=8, CIC_N=1, rate 1, inputs 127 then −128 -> outputs 127, then −128−127 = 1 (mod 256).
- Reset asserted with outputs in flight -> next cycle m_axis_out_tvalid=0, data=0. After release, the first output equals the first decimated sample (delay lines zero).

Source files
------------

// File: rtl/cic_decim_comb_chain.sv
// cic_decim_comb_chain: CIC decimator back half (downsampler, CIC_N comb stages, output register)
//   clk, reset_n             : clock, synchronous active-low reset
//   s_axis_in_tdata/tvalid   : integrator-chain samples
//   s_axis_rate_tdata/tvalid : run-time decimation ratio load (VARIABLE_RATE=1 only)
//   m_axis_out_tdata/tvalid  : MSB-aligned comb output, one-cycle valid pulse
module cic_decim_comb_chain #(
  parameter int DW            = 32,
  parameter int OUT_DW        = 32,
  parameter int RATE_DW       = 16,
  parameter int CIC_R         = 10,
  parameter int CIC_N         = 3,
  parameter int CIC_M         = 1,
  parameter int VARIABLE_RATE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DW-1:0]      s_axis_in_tdata,
  input  logic               s_axis_in_tvalid,
  input  logic [RATE_DW-1:0] s_axis_rate_tdata,
  input  logic               s_axis_rate_tvalid,
  output logic [OUT_DW-1:0]  m_axis_out_tdata,
  output logic               m_axis_out_tvalid
);
  logic [RATE_DW-1:0] r_rate, r_cnt, w_new_rate, w_rate, w_cnt_base;
  logic               w_load, w_emit;
  logic [DW-1:0]      r_ds_data;
  logic               r_ds_valid;
  logic [CIC_N:0][DW-1:0] w_cd;
  logic [CIC_N:0]         w_cv;
  // A rate load restarts the period, so a coincident sample is counted from zero under the new rate
  assign w_load     = (VARIABLE_RATE != 0) && s_axis_rate_tvalid && (s_axis_rate_tdata != '0);
  assign w_new_rate = (s_axis_rate_tdata > RATE_DW'(CIC_R)) ? RATE_DW'(CIC_R) : s_axis_rate_tdata;
  assign w_rate     = w_load ? w_new_rate : r_rate;
  assign w_cnt_base = w_load ? '0 : r_cnt;
  assign w_emit     = s_axis_in_tvalid && (w_cnt_base == w_rate - 1'b1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rate     <= RATE_DW'(CIC_R);
      r_cnt      <= '0;
      r_ds_data  <= '0;
      r_ds_valid <= 1'b0;
    end else begin
      r_rate     <= w_rate;
      r_cnt      <= w_emit ? '0 : w_cnt_base + RATE_DW'(s_axis_in_tvalid);
      r_ds_valid <= w_emit;
      if (w_emit) r_ds_data <= s_axis_in_tdata;
    end
  end
  assign w_cd[0] = r_ds_data;
  assign w_cv[0] = r_ds_valid;
  genvar k;
  for (k = 0; k < CIC_N; k++) begin : g_comb
    logic [CIC_M-1:0][DW-1:0] r_dl;
    logic [CIC_M:0][DW-1:0]   w_sh;
    logic [DW-1:0]            r_y;
    logic                     r_v;
    // w_sh is the delay line with the new sample shifted in at index 0
    assign w_sh = {r_dl, w_cd[k]};
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_dl <= '0;
        r_y  <= '0;
        r_v  <= 1'b0;
      end else begin
        r_v <= w_cv[k];
        if (w_cv[k]) begin
          r_y  <= w_cd[k] - r_dl[CIC_M-1];
          r_dl <= w_sh[CIC_M-1:0];
        end
      end
    end
    assign w_cd[k+1] = r_y;
    assign w_cv[k+1] = r_v;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
    end else begin
      m_axis_out_tvalid <= w_cv[CIC_N];
      if (w_cv[CIC_N]) m_axis_out_tdata <= w_cd[CIC_N][DW-1 -: OUT_DW];
    end
  end
endmodule

// File: tb/tb_cic_decim_comb_chain.sv
// tb_cic_decim_comb_chain: scoreboard bench for the variable-rate comb chain plus a fixed-rate wrap instance
module tb_cic_decim_comb_chain;
  localparam int A_DW = 16, A_OW = 12, A_R = 8, A_N = 2, A_M = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [A_DW-1:0] a_in = '0;
  logic a_v = 1'b0, a_rv = 1'b0;
  logic [15:0] a_rd = '0;
  logic [A_OW-1:0] a_out;
  logic a_ov;
  logic [7:0] b_in = '0;
  logic b_v = 1'b0, b_rv = 1'b0;
  logic [3:0] b_rd = '0;
  logic [7:0] b_out;
  logic b_ov;
  int n_checks = 0, n_fail = 0, cyc = 0;
  typedef struct { logic [A_OW-1:0] d; int c; } exp_t;
  exp_t q[$];
  int m_rate = A_R, m_cnt = 0;
  logic [A_DW-1:0] m_h [A_N][A_M];
  logic [A_OW-1:0] last = '0;

  cic_decim_comb_chain #(.DW(A_DW), .OUT_DW(A_OW), .RATE_DW(16), .CIC_R(A_R), .CIC_N(A_N), .CIC_M(A_M), .VARIABLE_RATE(1)) dut (
    .clk(clk), .reset_n(reset_n), .s_axis_in_tdata(a_in), .s_axis_in_tvalid(a_v),
    .s_axis_rate_tdata(a_rd), .s_axis_rate_tvalid(a_rv), .m_axis_out_tdata(a_out), .m_axis_out_tvalid(a_ov));
  cic_decim_comb_chain #(.DW(8), .OUT_DW(8), .RATE_DW(4), .CIC_R(1), .CIC_N(1), .CIC_M(1), .VARIABLE_RATE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_axis_in_tdata(b_in), .s_axis_in_tvalid(b_v),
    .s_axis_rate_tdata(b_rd), .s_axis_rate_tvalid(b_rv), .m_axis_out_tdata(b_out), .m_axis_out_tvalid(b_ov));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(posedge clk) begin
    #1;
    if (!reset_n) last = '0;
    else if (a_ov) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got 0x%0h at cycle %0d, required no output", a_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (a_out !== e.d || cyc !== e.c) begin
          n_fail++;
          $display("FAIL out_data: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d", a_out, cyc, e.d, e.c);
        end
      end
      last = a_out;
    end else begin
      n_checks++;
      if (a_out !== last) begin
        n_fail++;
        $display("FAIL out_hold: got 0x%0h, required 0x%0h", a_out, last);
      end
    end
  end

  task automatic model_reset();
    m_rate = A_R;
    m_cnt = 0;
    for (int s = 0; s < A_N; s++) for (int j = 0; j < A_M; j++) m_h[s][j] = '0;
    q.delete();
  endtask

  task automatic model_step(input bit v, input logic [A_DW-1:0] x, input bit rv, input int rd);
    bit emit = 0;
    logic [A_DW-1:0] y, t;
    if (rv && rd != 0) begin
      m_rate = (rd > A_R) ? A_R : rd;
      m_cnt = 0;
    end
    if (v) begin
      if (m_cnt == m_rate - 1) begin emit = 1; m_cnt = 0; end
      else m_cnt++;
    end
    if (emit) begin
      y = x;
      for (int s = 0; s < A_N; s++) begin
        t = y - m_h[s][A_M-1];
        for (int j = A_M - 1; j > 0; j--) m_h[s][j] = m_h[s][j-1];
        m_h[s][0] = y;
        y = t;
      end
      q.push_back('{d: y[A_DW-1 -: A_OW], c: cyc + A_N + 2});
    end
  endtask

  task automatic drive(input bit v, input logic [A_DW-1:0] x, input bit rv, input int rd);
    @(negedge clk);
    a_v = v;
    a_in = x;
    a_rv = rv;
    a_rd = 16'(rd);
    model_step(v, x, rv, rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, a_in, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks += 2;
    if (a_ov !== 1'b0 || a_out !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got valid %b data 0x%0h, required 0 and 0", a_ov, a_out);
    end
    if (b_ov !== 1'b0 || b_out !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got valid %b data 0x%0h, required 0 and 0", b_ov, b_out);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_rate();
    for (int i = 0; i < 40; i++) drive(1, 16'($urandom), 0, 0);
    idle(6);
  endtask

  task automatic test_rate_load();
    for (int i = 0; i < 5; i++) drive(1, 16'($urandom), 0, 0);
    drive(1, 16'($urandom), 1, 2);
    for (int i = 0; i < 15; i++) drive(1, 16'($urandom), 0, 0);
    drive(1, 16'($urandom), 1, 0);
    for (int i = 0; i < 6; i++) drive(1, 16'($urandom), 0, 0);
    drive(1, 16'($urandom), 1, 20);
    for (int i = 0; i < 24; i++) drive(1, 16'($urandom), 0, 0);
    idle(6);
  endtask

  task automatic test_back_to_back();
    drive(1, 16'h7ff0, 1, 1);
    for (int i = 0; i < 12; i++) drive(1, 16'($urandom), 0, 0);
    idle(6);
  endtask

  task automatic test_gapped();
    drive(0, '0, 1, 3);
    for (int i = 0; i < 36; i++) drive(i % 3 == 0, 16'($urandom), 0, 0);
    idle(6);
  endtask

  task automatic test_reset_inflight();
    drive(1, 16'($urandom), 1, 1);
    drive(1, 16'($urandom), 0, 0);
    drive(1, 16'($urandom), 0, 0);
    @(negedge clk);
    a_v = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (a_ov !== 1'b0 || a_out !== '0) begin
      n_fail++;
      $display("FAIL reset_inflight: got valid %b data 0x%0h, required 0 and 0", a_ov, a_out);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) drive(1, 16'($urandom), 0, 0);
    idle(6);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d [6] = '{8'h00, 8'h00, 8'h00, 8'h7f, 8'h01, 8'h01};
    bit exp_v [6] = '{0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (b_ov !== exp_v[i] || b_out !== exp_d[i]) begin
        n_fail++;
        $display("FAIL wrap_%0d: got valid %b data 0x%0h, required %b and 0x%0h", i, b_ov, b_out, exp_v[i], exp_d[i]);
      end
      b_v = (i < 2);
      b_in = (i == 0) ? 8'h7f : 8'h80;
      b_rv = 1'b1;
      b_rd = 4'd5;
    end
    b_v = 1'b0;
    b_rv = 1'b0;
  endtask

  task automatic test_drain();
    idle(8);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs still pending, required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_reset_rate();
    test_rate_load();
    test_back_to_back();
    test_gapped();
    test_reset_inflight();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
